// File: rtl/sdf_delay_mem_ctrl.sv
// SDF delay-line controller: drives a 1R1W SRAM wrapper and exposes a ready/valid FIFO
// with a 2-entry prefetch buffer. Optional define SDF_MEM_BYPASS_EN skips the SRAM when empty.
module sdf_delay_mem_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DEPTH  = 128
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              mem_W0_en,
    output logic [ADDR_W-1:0] mem_W0_addr,
    output logic [DATA_W-1:0] mem_W0_data,
    output logic              mem_R0_en,
    output logic [ADDR_W-1:0] mem_R0_addr,
    input  logic [DATA_W-1:0] mem_R0_data,
    output logic [ADDR_W+1:0] occupancy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wptr, rptr;
    logic [ADDR_W:0]   mem_cnt;
    logic              inflight;
    logic [1:0]        buf_cnt;
    logic [DATA_W-1:0] buf_head, buf_tail;

    logic              in_fire, out_fire, rd_issue, mem_wr, bypass, push;
    logic [1:0]        reserved;
    logic [DATA_W-1:0] push_data;

    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        in_ready  = (mem_cnt < FULL_CNT);
        in_fire   = in_valid & in_ready;
        out_valid = (buf_cnt != 2'd0);
        out_fire  = out_valid & out_ready;
        // Buffer slots already claimed by stored entries plus the read in flight.
        reserved  = buf_cnt + {1'b0, inflight};
        rd_issue  = (mem_cnt != '0)
                  & ((reserved < 2'd2) | (out_fire & (reserved == 2'd2)));
`ifdef SDF_MEM_BYPASS_EN
        bypass    = in_fire & (mem_cnt == '0) & ~inflight & (buf_cnt < 2'd2);
`else
        bypass    = 1'b0;
`endif
        mem_wr    = in_fire & ~bypass;
        push      = inflight | bypass;
        push_data = inflight ? mem_R0_data : in_data;
    end

    assign out_data    = buf_head;
    assign mem_W0_en   = mem_wr;
    assign mem_W0_addr = wptr;
    assign mem_W0_data = in_data;
    assign mem_R0_en   = rd_issue;
    assign mem_R0_addr = rptr;
    assign occupancy   = (ADDR_W + 2)'(mem_cnt) + (ADDR_W + 2)'(inflight)
                       + (ADDR_W + 2)'(buf_cnt);

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            mem_cnt  <= '0;
            inflight <= 1'b0;
            buf_cnt  <= 2'd0;
            buf_head <= '0;
            buf_tail <= '0;
        end else begin
            if (mem_wr) begin
                wptr <= ptr_inc(wptr);
            end
            if (rd_issue) begin
                rptr <= ptr_inc(rptr);
            end
            case ({mem_wr, rd_issue})
                2'b10:   mem_cnt <= mem_cnt + 1'b1;
                2'b01:   mem_cnt <= mem_cnt - 1'b1;
                default: mem_cnt <= mem_cnt;
            endcase
            inflight <= rd_issue;

            case ({push, out_fire})
                2'b10: begin
                    if (buf_cnt == 2'd0) begin
                        buf_head <= push_data;
                    end else begin
                        buf_tail <= push_data;
                    end
                    buf_cnt <= buf_cnt + 2'd1;
                end
                2'b01: begin
                    buf_head <= buf_tail;
                    buf_cnt  <= buf_cnt - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new sample lands behind whatever remains.
                    if (buf_cnt == 2'd1) begin
                        buf_head <= push_data;
                    end else begin
                        buf_head <= buf_tail;
                        buf_tail <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    hazard_a: assert property (@(posedge clock) disable iff (reset)
        !(mem_W0_en && mem_R0_en && (mem_W0_addr == mem_R0_addr)));
`endif

endmodule
